// File: rtl/pps_gen_pkg.sv
// Shared PPS definitions: generator state encoding and the pulse-width clamp.
// Also imported by the receive-side logic so both ends agree on width scaling.
package pps_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pps_state_t;

    // Width in clocks = width << shift, capped so every period keeps at least
    // one low cycle. Evaluated at 32 bits, enough for shift values up to 24.
    function automatic logic [31:0] clamp_width(
        input logic [31:0] width,
        input int unsigned shift,
        input int unsigned clk_freq
    );
        logic [31:0] width_clk;
        width_clk = width << shift;
        if (width_clk >= clk_freq) begin
            width_clk = clk_freq - 1;
        end
        return width_clk;
    endfunction

endpackage

// File: rtl/pps_period_counter.sv
// Free-running period counter with terminal-count flag and synchronous restart.
module pps_period_counter #(
    parameter int CLK_FREQ = 1000000,
    parameter int CW       = $clog2(CLK_FREQ)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clear_i,
    output logic [CW-1:0] count_o,
    output logic          tc_o
);

    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_reg <= '0;
        end else if (clear_i) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign count_o = count_reg;
    assign tc_o    = (count_reg == LAST);

endmodule

// File: rtl/pps_gen.sv
// PPS transmit generator: programmable-width pulse once per CLK_FREQ clocks,
// one-cycle period-start flag, seconds counter, optional re-phase by sync.
module pps_gen
    import pps_gen_pkg::*;
#(
    parameter int CLK_FREQ      = 1000000,
    parameter int WIDTH_SHIFT   = 16,
    parameter int DEFAULT_WIDTH = 10
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic [7:0]  width_i,
    input  logic        width_wr_i,
    input  logic        sync_i,
    input  logic        sync_en_i,
    output logic        pps_o,
    output logic        pps_flag_o,
    output logic [31:0] sec_count_o
);

    localparam int CW = $clog2(CLK_FREQ);

    pps_state_t    state_reg;
    logic [7:0]    width_reg;
    logic [7:0]    width_active_reg;
    logic          pps_reg;
    logic          flag_reg;
    logic [31:0]   sec_reg;

    logic [7:0]    width_load;
    logic [31:0]   width_clk_active;
    logic [31:0]   width_clk_load;
    logic [CW-1:0] count;
    logic [31:0]   count_ext;
    logic          tc;
    logic          accepted_sync;
    logic          period_start;
    logic          counter_clear;

    // A write landing on a period start is bypassed so it takes effect at once.
    assign width_load       = width_wr_i ? width_i : width_reg;
    assign width_clk_active = clamp_width({24'd0, width_active_reg}, WIDTH_SHIFT, CLK_FREQ);
    assign width_clk_load   = clamp_width({24'd0, width_load}, WIDTH_SHIFT, CLK_FREQ);
    assign count_ext        = 32'(count);

    assign accepted_sync = sync_i & sync_en_i & en_i;
    assign period_start  = en_i & ((state_reg == ST_IDLE) | tc | accepted_sync);
    assign counter_clear = ~en_i | period_start;

    pps_period_counter #(
        .CLK_FREQ (CLK_FREQ),
        .CW       (CW)
    ) u_period_counter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (counter_clear),
        .count_o (count),
        .tc_o    (tc)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            width_reg <= 8'(DEFAULT_WIDTH);
        end else if (width_wr_i) begin
            width_reg <= width_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg        <= ST_IDLE;
            pps_reg          <= 1'b0;
            flag_reg         <= 1'b0;
            sec_reg          <= '0;
            width_active_reg <= 8'(DEFAULT_WIDTH);
        end else if (!en_i) begin
            state_reg <= ST_IDLE;
            pps_reg   <= 1'b0;
            flag_reg  <= 1'b0;
            sec_reg   <= '0;
        end else if (period_start) begin
            flag_reg         <= 1'b1;
            sec_reg          <= sec_reg + 32'd1;
            width_active_reg <= width_load;
            if (width_clk_load == 32'd0) begin
                state_reg <= ST_LOW;
                pps_reg   <= 1'b0;
            end else begin
                // Holding pps high across a restart avoids a low glitch on sync.
                state_reg <= ST_HIGH;
                pps_reg   <= 1'b1;
            end
        end else begin
            flag_reg <= 1'b0;
            if (state_reg == ST_HIGH && (count_ext + 32'd1) == width_clk_active) begin
                state_reg <= ST_LOW;
                pps_reg   <= 1'b0;
            end
        end
    end

    assign pps_o       = pps_reg;
    assign pps_flag_o  = flag_reg;
    assign sec_count_o = sec_reg;

endmodule
